// File: rtl/scc_pkg.sv
// Shared definitions for the SCC run controller: FSM state encoding and
// the default per-core error-bit width.
package scc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } scc_state_e;

    localparam int SCC_ERR_W = 2;

endpackage

// File: rtl/scc_sat_counter.sv
// Up-counter with synchronous clear and enable. It optionally sticks at
// all-ones instead of wrapping.
module scc_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sat_en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !(sat_en && (&count_q))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/scc_run_ctrl.sv
// Run controller for NUM_CORES SCC cores. It sequences reset hold, the run
// under a cycle budget, and stop, with sticky halt and error capture.
module scc_run_ctrl
    import scc_pkg::*;
#(
    parameter int NUM_CORES  = 1,
    parameter int RST_HOLD   = 3,
    parameter int MAX_CYCLES = 1000,
    parameter int CNT_W      = 32,
    parameter int ERR_W      = SCC_ERR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_CORES-1:0]       core_halt_f,
    input  logic [NUM_CORES*ERR_W-1:0] core_err_bits,
    output logic                       core_rst,
    output logic [NUM_CORES-1:0]       core_clk_en,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       aborted,
    output logic [NUM_CORES-1:0]       halted_mask,
    output logic [NUM_CORES*ERR_W-1:0] err_latched,
    output logic                       err_any,
    output logic [CNT_W-1:0]           cycle_count
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    scc_state_e                 state_q, state_d;
    logic                       core_rst_q, core_rst_d;
    logic [NUM_CORES-1:0]       clk_en_q, clk_en_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;
    logic                       aborted_q, aborted_d;
    logic [NUM_CORES-1:0]       halted_q, halted_d;
    logic [NUM_CORES*ERR_W-1:0] err_q, err_d;
    logic                       err_any_q, err_any_d;

    logic [NUM_CORES-1:0]       halted_nxt;
    logic [NUM_CORES*ERR_W-1:0] err_nxt;
    logic                       launch;
    logic [HOLD_W-1:0]          hold_cnt;
    logic                       hold_last;
    logic                       budget_last;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign halted_nxt[g]               = halted_q[g] | core_halt_f[g];
        assign err_nxt[g*ERR_W +: ERR_W]   = err_q[g*ERR_W +: ERR_W] | core_err_bits[g*ERR_W +: ERR_W];
    end

    // The hold counter restarts on every launch, so it never needs to saturate.
    scc_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (launch),
        .en     (state_q == ST_RESET),
        .sat_en (1'b1),
        .count  (hold_cnt)
    );

    scc_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (launch),
        .en     (state_q == ST_RUN),
        .sat_en (1'b1),
        .count  (cycle_count)
    );

    assign hold_last   = (hold_cnt == HOLD_W'(RST_HOLD - 1));
    assign budget_last = (cycle_count == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        halted_d  = halted_q;
        err_d     = err_q;
        launch    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_d   = ST_RESET;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                    halted_d  = '0;
                    err_d     = '0;
                end
            end
            ST_RESET: begin
                if (hold_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                halted_d = halted_nxt;
                err_d    = err_nxt;
                // A halt beats the budget when both land in the same cycle.
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (&halted_nxt) begin
                    state_d = ST_DONE;
                end else if (budget_last) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        core_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
        busy_d     = (state_d == ST_RESET) || (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        err_any_d  = |err_d;
        case (state_d)
            ST_RESET: clk_en_d = '1;
            ST_RUN:   clk_en_d = ~halted_d;
            default:  clk_en_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            core_rst_q <= 1'b1;
            clk_en_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            aborted_q  <= 1'b0;
            halted_q   <= '0;
            err_q      <= '0;
            err_any_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            aborted_q  <= aborted_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
            err_any_q  <= err_any_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign core_clk_en = clk_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign aborted     = aborted_q;
    assign halted_mask = halted_q;
    assign err_latched = err_q;
    assign err_any     = err_any_q;

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Bench for scc_run_ctrl: directed sequences, a table of complete runs, and
// random traffic, all compared against a run-level reference model.
module tb_scc_run_ctrl;

    localparam int NC  = 4;
    localparam int RH  = 3;
    localparam int MC  = 1000;
    localparam int CW  = 32;
    localparam int EW  = 2;
    localparam int EWT = NC * EW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [NC-1:0]  core_halt_f = '0;
    logic [EWT-1:0] core_err_bits = '0;
    logic           core_rst;
    logic [NC-1:0]  core_clk_en;
    logic           busy, done, timeout, aborted, err_any;
    logic [NC-1:0]  halted_mask;
    logic [EWT-1:0] err_latched;
    logic [CW-1:0]  cycle_count;

    always #5 clk = ~clk;

    scc_run_ctrl #(
        .NUM_CORES(NC), .RST_HOLD(RH), .MAX_CYCLES(MC), .CNT_W(CW), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .core_halt_f(core_halt_f), .core_err_bits(core_err_bits),
        .core_rst(core_rst), .core_clk_en(core_clk_en), .busy(busy), .done(done),
        .timeout(timeout), .aborted(aborted), .halted_mask(halted_mask),
        .err_latched(err_latched), .err_any(err_any), .cycle_count(cycle_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which phase of a run we are in, plus the run's status.
    bit             m_resetting, m_running, m_finished, m_timeout, m_aborted;
    int             m_hold_left;
    logic [NC-1:0]  m_halted;
    logic [EWT-1:0] m_err;
    longint         m_count;

    task automatic model_clear();
        m_resetting = 0; m_running = 0; m_finished = 0;
        m_timeout = 0; m_aborted = 0; m_hold_left = 0;
        m_halted = '0; m_err = '0; m_count = 0;
    endtask

    task automatic finish_run();
        m_running  = 0;
        m_finished = 1;
    endtask

    task automatic model_step();
        if (!rst) begin
            model_clear();
        end else if (m_running) begin
            if (m_count < ((longint'(1) << CW) - 1)) m_count = m_count + 1;
            m_halted = m_halted | core_halt_f;
            m_err    = m_err | core_err_bits;
            if (abort) begin
                m_aborted = 1;
                finish_run();
            end else if (m_halted == {NC{1'b1}}) begin
                finish_run();
            end else if (m_count == MC) begin
                m_timeout = 1;
                finish_run();
            end
        end else if (m_resetting) begin
            m_hold_left = m_hold_left - 1;
            if (m_hold_left == 0) begin
                m_resetting = 0;
                m_running   = 1;
            end
        end else if (start) begin
            model_clear();
            m_resetting = 1;
            m_hold_left = RH;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_all();
        logic [NC-1:0] e_en;
        logic          e_rst;
        logic          e_busy;
        e_rst  = !m_running && !m_finished;
        e_busy = m_resetting || m_running;
        if (m_resetting)    e_en = '1;
        else if (m_running) e_en = ~m_halted;
        else                e_en = '0;
        check("core_rst", 64'(core_rst), 64'(e_rst));
        check("core_clk_en", 64'(core_clk_en), 64'(e_en));
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(m_finished));
        check("timeout", 64'(timeout), 64'(m_timeout));
        check("aborted", 64'(aborted), 64'(m_aborted));
        check("halted_mask", 64'(halted_mask), 64'(m_halted));
        check("err_latched", 64'(err_latched), 64'(m_err));
        check("err_any", 64'(err_any), 64'(m_err != '0));
        check("cycle_count", 64'(cycle_count), 64'(m_count));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance_to(input longint k);
        int guard;
        guard = 0;
        while (!(m_running && m_count == k) && guard < 3000) begin
            tick();
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++;
            $display("FAIL advance_to: run cycle %0d not reached (t=%0t)", k, $time);
        end
    endtask

    typedef struct {
        int            h0, h1, h2, h3, ab;
        logic          exp_to;
        logic          exp_ab;
        int            exp_cnt;
        logic [NC-1:0] exp_mask;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v, input int idx);
        int g;
        g = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && g < 1200) begin
            core_halt_f = '0;
            abort = 1'b0;
            if (m_running) begin
                if (m_count == v.h0) core_halt_f[0] = 1'b1;
                if (m_count == v.h1) core_halt_f[1] = 1'b1;
                if (m_count == v.h2) core_halt_f[2] = 1'b1;
                if (m_count == v.h3) core_halt_f[3] = 1'b1;
                if (m_count == v.ab) abort = 1'b1;
            end
            tick();
            g++;
        end
        core_halt_f = '0;
        abort = 1'b0;
        check($sformatf("vec%0d done", idx), 64'(done), 64'(1));
        check($sformatf("vec%0d timeout", idx), 64'(timeout), 64'(v.exp_to));
        check($sformatf("vec%0d aborted", idx), 64'(aborted), 64'(v.exp_ab));
        check($sformatf("vec%0d cycle_count", idx), 64'(cycle_count), 64'(v.exp_cnt));
        check($sformatf("vec%0d halted_mask", idx), 64'(halted_mask), 64'(v.exp_mask));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{40, 40, 40, 40, -1, 1'b0, 1'b0, 41, 4'hF};
        vecs[1] = '{10, 20, 20, 55, -1, 1'b0, 1'b0, 56, 4'hF};
        vecs[2] = '{-1, -1, -1, -1, -1, 1'b1, 1'b0, 1000, 4'h0};
        vecs[3] = '{999, 999, 999, 999, -1, 1'b0, 1'b0, 1000, 4'hF};
        vecs[4] = '{-1, -1, -1, -1, 6, 1'b0, 1'b1, 7, 4'h0};
        vecs[5] = '{-1, 5, -1, -1, 6, 1'b0, 1'b1, 7, 4'h2};
        vecs[6] = '{12, 12, 12, 12, 12, 1'b0, 1'b1, 13, 4'hF};
        vecs[7] = '{3, -1, -1, -1, -1, 1'b1, 1'b0, 1000, 4'h1};
        vecs[8] = '{0, 0, 0, 0, -1, 1'b0, 1'b0, 1, 4'hF};

        // Reset state
        model_clear();
        @(negedge clk);
        compare_all();
        tick();
        rst = 1'b1;
        tick();

        // Reset hold with junk halts, then counting, then abort in the 7th RUN cycle
        start = 1'b1;
        core_halt_f = 4'hF;
        tick();
        start = 1'b0;
        for (int i = 0; i < RH; i++) begin
            check("hold core_rst", 64'(core_rst), 64'(1));
            check("hold clk_en", 64'(core_clk_en), 64'(4'hF));
            tick();
        end
        core_halt_f = '0;
        check("run entry core_rst", 64'(core_rst), 64'(0));
        check("run entry halted_mask", 64'(halted_mask), 64'(0));
        check("run entry clk_en", 64'(core_clk_en), 64'(4'hF));
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("run count", 64'(cycle_count), 64'(k));
        end
        advance_to(6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort done", 64'(done), 64'(1));
        check("abort aborted", 64'(aborted), 64'(1));
        check("abort count", 64'(cycle_count), 64'(7));

        // Abort held through RESET only acts once RUN is entered
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < RH; i++) begin
            check("abort-in-reset busy", 64'(busy), 64'(1));
            tick();
        end
        tick();
        abort = 1'b0;
        check("abort-after-reset aborted", 64'(aborted), 64'(1));
        check("abort-after-reset count", 64'(cycle_count), 64'(1));

        // Table of complete runs
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Error capture, hold through DONE, clear on restart
        start = 1'b1;
        tick();
        start = 1'b0;
        advance_to(15);
        core_err_bits[5:4] = 2'b10;
        tick();
        core_err_bits = '0;
        advance_to(30);
        core_err_bits[1:0] = 2'b01;
        tick();
        core_err_bits = '0;
        advance_to(40);
        core_halt_f = 4'hF;
        tick();
        core_halt_f = '0;
        check("err done", 64'(done), 64'(1));
        check("err latched", 64'(err_latched), 64'(8'h21));
        check("err any", 64'(err_any), 64'(1));
        for (int i = 0; i < 3; i++) tick();
        check("err held", 64'(err_latched), 64'(8'h21));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err cleared", 64'(err_latched), 64'(0));
        check("err_any cleared", 64'(err_any), 64'(0));

        // Asynchronous reset in the middle of a run
        advance_to(100);
        core_halt_f = 4'h4;
        core_err_bits = 8'hC0;
        tick();
        core_halt_f = '0;
        core_err_bits = '0;
        advance_to(500);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check("async core_rst", 64'(core_rst), 64'(1));
        check("async clk_en", 64'(core_clk_en), 64'(0));
        check("async busy", 64'(busy), 64'(0));
        check("async done", 64'(done), 64'(0));
        check("async halted", 64'(halted_mask), 64'(0));
        check("async err", 64'(err_latched), 64'(0));
        check("async count", 64'(cycle_count), 64'(0));
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NC; i++) core_halt_f[i] = ($urandom_range(0, 24) == 0);
            core_err_bits = ($urandom_range(0, 9) == 0) ? EWT'($urandom) : '0;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        core_halt_f = '0;
        core_err_bits = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scc_run_ctrl.md
Name: scc_run_ctrl

Overview:
Synthesizable run controller that sequences one or more SCC cores through reset, enable, run and stop. It replaces hand-written bench sequencing: a programmable reset hold, a cycle budget, per-core halt tracking, sticky error capture and timeout detection. It sits between the bench or SoC control logic and NUM_CORES instances of scc_f25_top, and drives each core's rst and clk_en.

Parameters:
NUM_CORES, 1, number of cores controlled (1..8)
RST_HOLD, 3, cycles core_rst stays high in RESET state (>=1)
MAX_CYCLES, 1000, RUN-cycle budget before timeout (>=1)
CNT_W, 32, width of cycle_count; must hold MAX_CYCLES
ERR_W, 2, width of each core's err_bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset of this block
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
abort  in  1  level; forces the run to end
core_halt_f  in  NUM_CORES  per-core halt flag
core_err_bits  in  NUM_CORES*ERR_W  per-core error bits, core i at [i*ERR_W +: ERR_W]
core_rst  out  1  active-high reset to all cores
core_clk_en  out  NUM_CORES  per-core clock enable
busy  out  1  high in RESET or RUN
done  out  1  high in DONE
timeout  out  1  run ended on budget exhaustion
aborted  out  1  run ended by abort
halted_mask  out  NUM_CORES  sticky per-core halt seen
err_latched  out  NUM_CORES*ERR_W  sticky OR of core_err_bits during RUN
err_any  out  1  OR-reduction of err_latched
cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- rst low, asynchronous: state=IDLE, core_rst=1, core_clk_en=0, busy=0, done=0, timeout=0, aborted=0, halted_mask=0, err_latched=0, cycle_count=0, hold counter=0.
- FSM: IDLE, RESET, RUN, DONE. All outputs are registered.
- IDLE: core_rst=1, core_clk_en=0. A start pulse moves to RESET on the next edge, clears all status, loads the hold counter.
- RESET: core_rst=1, core_clk_en=all 1s, so the cores see RST_HOLD enabled edges under reset. After exactly RST_HOLD cycles in RESET, go to RUN.
- RUN: core_rst=0.
  - cycle_count increments by 1 each RUN cycle; it saturates and never wraps.
  - core_clk_en[i] = ~halted_mask[i].
  - halted_mask[i] sets in the cycle after core_halt_f[i] is sampled high during RUN; core i's clk_en drops in that same cycle.
  - err_latched |= core_err_bits on every RUN cycle.
- RUN exit, priority order, evaluated per cycle:
  1. abort=1: DONE with aborted=1.
  2. All bits of the next halted_mask set: DONE with timeout=0.
  3. cycle_count == MAX_CYCLES-1 on this increment: DONE with timeout=1.
  - A halt and the budget expiring in the same cycle count as a halt (timeout=0).
- DONE: core_clk_en=0, core_rst=0 so core state stays inspectable; done=1. Status outputs hold. start moves to RESET and clears status; other inputs are ignored.
- start is ignored while busy=1. abort in IDLE, RESET or DONE is ignored; abort during RESET takes effect only once RUN is entered.
- Halts sampled outside RUN are ignored. This covers junk on halt_f while a core is in reset.
- rst asserted mid-run aborts immediately to reset values. No DONE pulse is produced.

Decomposition:
- Shared package scc_pkg: FSM state encoding (IDLE=2'd0, RESET=2'd1, RUN=2'd2, DONE=2'd3) and ERR_W default.
- One sub-module, scc_sat_counter (parametrised width, clear, enable, saturate flag). It is used for both the hold counter and cycle_count.
- Per-core halt/err logic is a generate loop, not a sub-module.

Test Plan:
- Reset hold (NUM_CORES=1, RST_HOLD=3): release rst, pulse start -> core_rst high exactly 3 cycles with clk_en=1, then RUN with cycle_count counting 1,2,3...
- Single-core halt: halt_f raised at RUN cycle 40 -> halted_mask=1 and core_clk_en=0 one cycle later; done=1, timeout=0; cycle_count stops at 41.
- Timeout (MAX_CYCLES=1000, no halt) -> done=1, timeout=1, cycle_count=1000 exactly; raising halt on the final cycle gives timeout=0 instead.
- Multi-core (NUM_CORES=4): halts at cycles 10, 20, 20, 55 -> clk_en bits drop individually, halted_mask steps 0001, 0111, 1111; DONE after the cycle-55 halt.
- Errors: core 2 pulses err_bits=2'b10 for one cycle at cycle 15, core 0 pulses 2'b01 at cycle 30 -> err_latched[5:4]=10 and [1:0]=01, err_any=1, both held through DONE and cleared on the next start.
- Abort and rst: abort asserted at RUN cycle 7 -> DONE, aborted=1, cycle_count=7. Separately, rst low at cycle 500 -> every output at its reset value within the same cycle (asynchronous), state IDLE.
